dm_arbiter: RTL and testbench

//   Two-port arbiter/sequencer in front of the data memory (dm). Shares dm between

---
 rtl/dm_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_dm_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin two-master sequencer in front of the data memory.
// Each access takes IDLE -> ACCESS -> DONE; illegal accesses never reach dm.
module dm_arbiter #(
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_2000,
    parameter bit          PRIO_FIXED = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [1:0]  m0_size,
    input  logic        m0_sext,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [1:0]  m1_size,
    input  logic        m1_sext,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic        dm_we,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t      r_state;
    logic        r_last;      // id of the master granted most recently
    logic        r_gnt;       // id of the master owning the current access
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_sext;
    logic [1:0]  r_addr_lo;
    logic        r_err;

    logic        w_any_req;
    logic        w_gnt;
    logic        w_sel_we;
    logic [1:0]  w_sel_size;
    logic        w_sel_sext;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic        w_legal;
    logic [3:0]  w_be;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_result;

    // Arbitration and selection of the winning master's request fields.
    always_comb begin
        w_any_req = m0_req | m1_req;
        if (m0_req && m1_req) begin
            w_gnt = PRIO_FIXED ? 1'b0 : ~r_last;
        end else begin
            w_gnt = m1_req;
        end
        w_sel_we    = w_gnt ? m1_we    : m0_we;
        w_sel_size  = w_gnt ? m1_size  : m0_size;
        w_sel_sext  = w_gnt ? m1_sext  : m0_sext;
        w_sel_addr  = w_gnt ? m1_addr  : m0_addr;
        w_sel_wdata = w_gnt ? m1_wdata : m0_wdata;
    end

    // Legality check and byte-enable generation for the selected request.
    always_comb begin
        w_legal = 1'b1;
        w_be    = 4'b0000;
        case (w_sel_size)
            SZ_BYTE: w_be = 4'b0001 << w_sel_addr[1:0];
            SZ_HALF: begin
                w_be = w_sel_addr[1] ? 4'b1100 : 4'b0011;
                if (w_sel_addr[0]) w_legal = 1'b0;
            end
            SZ_WORD: begin
                w_be = 4'b1111;
                if (w_sel_addr[1:0] != 2'b00) w_legal = 1'b0;
            end
            default: w_legal = 1'b0;
        endcase
        if (w_sel_addr >= ADDR_LIMIT) w_legal = 1'b0;
    end

    // Lane extraction and extension of the dm read word during ACCESS.
    always_comb begin
        w_byte = 8'h00;
        case (r_addr_lo)
            2'd0:    w_byte = dm_rdata[7:0];
            2'd1:    w_byte = dm_rdata[15:8];
            2'd2:    w_byte = dm_rdata[23:16];
            default: w_byte = dm_rdata[31:24];
        endcase
        w_half = r_addr_lo[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (r_size)
            SZ_BYTE: w_result = {{24{r_sext & w_byte[7]}}, w_byte};
            SZ_HALF: w_result = {{16{r_sext & w_half[15]}}, w_half};
            default: w_result = dm_rdata;
        endcase
        if (r_we || r_err) w_result = 32'h0000_0000;
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_last    <= 1'b1;
            r_gnt     <= 1'b0;
            r_we      <= 1'b0;
            r_size    <= 2'b00;
            r_sext    <= 1'b0;
            r_addr_lo <= 2'b00;
            r_err     <= 1'b0;
            m0_ack    <= 1'b0;
            m0_err    <= 1'b0;
            m0_rdata  <= 32'h0000_0000;
            m1_ack    <= 1'b0;
            m1_err    <= 1'b0;
            m1_rdata  <= 32'h0000_0000;
            dm_we     <= 1'b0;
            dm_be     <= 4'b0000;
            dm_addr   <= 32'h0000_0000;
            dm_wdata  <= 32'h0000_0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_gnt     <= w_gnt;
                        r_we      <= w_sel_we;
                        r_size    <= w_sel_size;
                        r_sext    <= w_sel_sext;
                        r_addr_lo <= w_sel_addr[1:0];
                        r_err     <= ~w_legal;
                        dm_addr   <= w_sel_addr;
                        dm_wdata  <= w_sel_wdata;
                        dm_we     <= w_legal & w_sel_we;
                        dm_be     <= w_legal ? w_be : 4'b0000;
                        r_state   <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    dm_we   <= 1'b0;
                    dm_be   <= 4'b0000;
                    if (r_gnt) begin
                        m1_ack   <= 1'b1;
                        m1_err   <= r_err;
                        m1_rdata <= w_result;
                    end else begin
                        m0_ack   <= 1'b1;
                        m0_err   <= r_err;
                        m0_rdata <= w_result;
                    end
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    m0_ack  <= 1'b0;
                    m0_err  <= 1'b0;
                    m1_ack  <= 1'b0;
                    m1_err  <= 1'b0;
                    r_last  <= r_gnt;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: randomized and directed bench for dm_arbiter against a
// byte-addressed memory model and a transaction-level arbitration model.
module tb_dm_arbiter;

    localparam logic [31:0] LIMIT = 32'h0000_2000;

    logic        clk;
    logic        reset;
    logic        m0_req, m0_we, m0_sext;
    logic [1:0]  m0_size;
    logic [31:0] m0_addr, m0_wdata;
    logic        m0_ack, m0_err;
    logic [31:0] m0_rdata;
    logic        m1_req, m1_we, m1_sext;
    logic [1:0]  m1_size;
    logic [31:0] m1_addr, m1_wdata;
    logic        m1_ack, m1_err;
    logic [31:0] m1_rdata;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;

    int checks = 0;
    int errors = 0;
    logic ref_last;                 // master granted most recently
    logic [7:0] ref_mem [0:8191];   // expected dm contents, byte view
    logic [31:0] dm_mem [0:2047];   // physical dm seen by the DUT
    logic tb_init;
    int wr_lo;

    dm_arbiter #(.ADDR_LIMIT(LIMIT), .PRIO_FIXED(1'b0)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_sext(m0_sext),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_err(m0_err),
        .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_sext(m1_sext),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_err(m1_err),
        .m1_rdata(m1_rdata),
        .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int w);
        return (32'(w) * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // dm model: combinational read, lanes placed from right-justified data by BE.
    assign dm_rdata = dm_mem[dm_addr[12:2]];
    always @(posedge clk) begin
        if (tb_init) begin
            for (int w = 0; w < 2048; w++) dm_mem[w] <= init_word(w);
        end else if (dm_we) begin
            wr_lo = 0;
            for (int i = 3; i >= 0; i--) if (dm_be[i]) wr_lo = i;
            for (int i = 0; i < 4; i++)
                if (dm_be[i]) dm_mem[dm_addr[12:2]][8*i +: 8] <= dm_wdata[8*(i-wr_lo) +: 8];
        end
    end

    function automatic logic ref_legal(input logic [1:0] size, input logic [31:0] addr);
        return (size != 2'b11) && ((addr & ((32'd1 << size) - 32'd1)) == 32'd0) && (addr < LIMIT);
    endfunction

    function automatic logic [3:0] ref_be(input logic [1:0] size, input logic [31:0] addr);
        int nb;
        int mask;
        nb = 1 << size;
        mask = (1 << nb) - 1;
        return 4'(mask << addr[1:0]);
    endfunction

    task automatic ref_access(input logic we, input logic [1:0] size, input logic sext,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output logic err, output logic [31:0] rd);
        int nb;
        logic [31:0] v;
        nb = 1 << size;
        err = !ref_legal(size, addr);
        rd = 32'h0;
        if (!err) begin
            if (we) begin
                for (int k = 0; k < nb; k++) ref_mem[13'(addr + 32'(k))] = wdata[8*k +: 8];
            end else begin
                v = 32'h0;
                for (int k = 0; k < nb; k++) v[8*k +: 8] = ref_mem[13'(addr + 32'(k))];
                if (sext && nb < 4 && v[8*nb-1])
                    for (int b = 8*nb; b < 32; b++) v[b] = 1'b1;
                rd = v;
            end
        end
    endtask

    task automatic drive(input int m, input logic req, input logic we, input logic [1:0] size,
                         input logic sext, input logic [31:0] addr, input logic [31:0] wdata);
        if (m == 0) begin
            m0_req = req; m0_we = we; m0_size = size; m0_sext = sext;
            m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = req; m1_we = we; m1_size = size; m1_sext = sext;
            m1_addr = addr; m1_wdata = wdata;
        end
    endtask

    // Single-master access from IDLE; checks dm signals in ACCESS and the reply in DONE.
    task automatic do_op(input int m, input logic we, input logic [1:0] size, input logic sext,
                         input logic [31:0] addr, input logic [31:0] wdata, input string name);
        logic e_err, e_legal, ack, oack, err;
        logic [31:0] e_rd, rd;
        logic [3:0] e_be;
        @(negedge clk);
        drive(m, 1'b1, we, size, sext, addr, wdata);
        e_legal = ref_legal(size, addr);
        e_be = e_legal ? ref_be(size, addr) : 4'b0000;
        ref_access(we, size, sext, addr, wdata, e_err, e_rd);
        @(negedge clk);
        checks++;
        if (dm_we !== (e_legal & we)) begin
            errors++; $display("FAIL %s dm_we got %b want %b", name, dm_we, e_legal & we);
        end
        checks++;
        if (dm_be !== e_be) begin
            errors++; $display("FAIL %s dm_be got %b want %b", name, dm_be, e_be);
        end
        checks++;
        if (dm_addr !== addr) begin
            errors++; $display("FAIL %s dm_addr got %h want %h", name, dm_addr, addr);
        end
        if (e_legal && we) begin
            checks++;
            if (dm_wdata !== wdata) begin
                errors++; $display("FAIL %s dm_wdata got %h want %h", name, dm_wdata, wdata);
            end
        end
        // Inputs changing after grant must not affect the result.
        drive(m, 1'b1, we, ~size, ~sext, ~addr, ~wdata);
        @(negedge clk);
        ack = (m == 0) ? m0_ack : m1_ack;
        checks++;
        if (ack !== 1'b1) begin
            errors++; $display("FAIL %s ack_latency got %b want 1", name, ack);
            for (int i = 0; i < 10 && ack !== 1'b1; i++) begin
                @(negedge clk);
                ack = (m == 0) ? m0_ack : m1_ack;
            end
        end
        oack = (m == 0) ? m1_ack : m0_ack;
        err  = (m == 0) ? m0_err : m1_err;
        rd   = (m == 0) ? m0_rdata : m1_rdata;
        checks++;
        if (oack !== 1'b0) begin
            errors++; $display("FAIL %s other_ack got %b want 0", name, oack);
        end
        checks++;
        if (err !== e_err) begin
            errors++; $display("FAIL %s err got %b want %b", name, err, e_err);
        end
        checks++;
        if (rd !== e_rd) begin
            errors++; $display("FAIL %s rdata got %h want %h", name, rd, e_rd);
        end
        ref_last = m[0];
        drive(m, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset;
        checks++;
        if ({m0_ack, m0_err, m1_ack, m1_err, dm_we, dm_be} !== 9'h0) begin
            errors++; $display("FAIL reset_ctrl got %b want 0", {m0_ack, m0_err, m1_ack, m1_err, dm_we, dm_be});
        end
        checks++;
        if ({m0_rdata, m1_rdata, dm_addr, dm_wdata} !== 128'h0) begin
            errors++; $display("FAIL reset_data got %h want 0", {m0_rdata, m1_rdata, dm_addr, dm_wdata});
        end
    endtask

    task automatic test_store_load;
        do_op(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, "sw_m0");
        do_op(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "lw_m0");
        checks++;
        if (m0_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL lw_const got %h want deadbeef", m0_rdata);
        end
    endtask

    task automatic test_extend;
        do_op(1, 1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF_0000, "sw_m1");
        do_op(1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, "lb");
        checks++;
        if (m1_rdata !== 32'hFFFF_FF80) begin
            errors++; $display("FAIL lb_const got %h want ffffff80", m1_rdata);
        end
        do_op(1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, "lbu");
        checks++;
        if (m1_rdata !== 32'h0000_0080) begin
            errors++; $display("FAIL lbu_const got %h want 00000080", m1_rdata);
        end
        do_op(1, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, "lh");
        checks++;
        if (m1_rdata !== 32'hFFFF_80FF) begin
            errors++; $display("FAIL lh_const got %h want ffff80ff", m1_rdata);
        end
        do_op(1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, "lhu");
    endtask

    task automatic test_errors;
        do_op(0, 1'b1, 2'b01, 1'b0, 32'h11, 32'h1234, "sh_misaligned");
        do_op(0, 1'b0, 2'b10, 1'b0, LIMIT, 32'h0, "lw_oor");
        do_op(0, 1'b0, 2'b11, 1'b0, 32'h20, 32'h0, "size_rsvd");
        do_op(0, 1'b1, 2'b10, 1'b0, 32'h22, 32'h5555_AAAA, "sw_misaligned");
        do_op(1, 1'b0, 2'b01, 1'b1, LIMIT - 32'd2, 32'h0, "lh_top");
        do_op(1, 1'b1, 2'b00, 1'b0, LIMIT - 32'd1, 32'h0000_005A, "sb_top");
    endtask

    task automatic test_byte_store;
        do_op(1, 1'b1, 2'b00, 1'b0, 32'h06, 32'h0000_00AB, "sb_lane2");
        do_op(1, 1'b0, 2'b10, 1'b0, 32'h04, 32'h0, "lw_lane2");
        checks++;
        if (m1_rdata[23:16] !== 8'hAB) begin
            errors++; $display("FAIL sb_lane2_byte got %h want ab", m1_rdata[23:16]);
        end
    endtask

    // Both masters hold requests; grants must alternate and never overlap.
    task automatic test_arbitration(input int n_grants);
        logic e0, e1;
        logic [31:0] r0, r1;
        logic win;
        int got;
        got = 0;
        ref_access(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, e0, r0);
        ref_access(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, e1, r1);
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        drive(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h80, 32'h0);
        for (int cyc = 0; cyc < 60 && got < n_grants; cyc++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) begin
                checks++;
                if ({m0_ack, m1_ack} === 2'b11) begin
                    errors++; $display("FAIL arb_double_ack got 11 want one-hot");
                end
                win = m1_ack;
                checks++;
                if (win !== ~ref_last) begin
                    errors++; $display("FAIL arb_order grant %0d got m%0d want m%0d", got, win, ~ref_last);
                end
                checks++;
                if ((win ? m1_rdata : m0_rdata) !== (win ? r1 : r0)) begin
                    errors++; $display("FAIL arb_rdata got %h want %h", win ? m1_rdata : m0_rdata, win ? r1 : r0);
                end
                ref_last = win;
                got++;
            end
        end
        checks++;
        if (got !== n_grants) begin
            errors++; $display("FAIL arb_timeout got %0d want %0d grants", got, n_grants);
        end
        drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    endtask

    // Reset during ACCESS abandons the access and restores m0 tie priority.
    task automatic test_reset_mid;
        int seen;
        do_op(0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, "pre_reset");
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        drive(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h80, 32'h0);
        @(negedge clk);
        checks++;
        if (dm_be !== 4'b1111) begin
            errors++; $display("FAIL rst_mid_access dm_be got %b want 1111", dm_be);
        end
        reset = 1'b1;
        @(negedge clk);
        test_reset();
        reset = 1'b0;
        ref_last = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({m0_ack, m1_ack} !== 2'b10) begin
            errors++; $display("FAIL rst_rearb acks got %b want 10", {m0_ack, m1_ack});
        end
        drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        seen = 0;
        for (int cyc = 0; cyc < 8 && seen == 0; cyc++) begin
            @(negedge clk);
            if (m1_ack) seen = 1;
        end
        checks++;
        if (seen !== 1) begin
            errors++; $display("FAIL rst_pending_m1 got no ack want ack");
        end
        ref_last = 1'b1;
        drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_random(input int n);
        int m;
        logic we, sext;
        logic [1:0] size;
        logic [31:0] addr;
        for (int i = 0; i < n; i++) begin
            m = int'($urandom_range(0, 1));
            we = 1'($urandom);
            sext = 1'($urandom);
            size = 2'($urandom_range(0, 3));
            addr = 32'($urandom_range(0, 32'h1FFF));
            if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << size[0]) << size[1]) + 32'd1 - 32'd1;
            if ($urandom_range(0, 3) != 0 && size != 2'b11) addr = addr & ~((32'd1 << size) - 32'd1);
            if ($urandom_range(0, 9) == 0) addr = LIMIT + 32'($urandom_range(0, 255));
            do_op(m, we, size, sext, addr, $urandom, "random");
        end
    endtask

    initial begin
        logic [31:0] w;
        reset = 1'b1;
        tb_init = 1'b1;
        ref_last = 1'b1;
        drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 2048; i++) begin
            w = init_word(i);
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        test_reset();
        reset = 1'b0;
        tb_init = 1'b0;
        test_store_load();
        test_extend();
        test_errors();
        test_byte_store();
        test_arbitration(4);
        test_reset_mid();
        test_random(80);
        test_arbitration(6);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
